// File: rtl/usb_pkg.sv
// ---------------------------------------------------------------------------
// usb_pkg
// Shared definitions for the USB link-layer host scheduler:
//   - token / handshake PID encodings
//   - scheduler state enumeration
// ---------------------------------------------------------------------------
package usb_pkg;

  localparam logic [3:0] PID_OUT   = 4'b0001;
  localparam logic [3:0] PID_IN    = 4'b1001;
  localparam logic [3:0] PID_ACK   = 4'b0010;
  localparam logic [3:0] PID_NAK   = 4'b1010;
  localparam logic [3:0] PID_STALL = 4'b1110;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_TOKEN,
    ST_TOK_WAIT,
    ST_DATA_TX,
    ST_WAIT_HS,
    ST_WAIT_DATA,
    ST_SEND_ACK,
    ST_RETRY,
    ST_DONE,
    ST_ERR
  } sched_state_e;

endpackage

// File: rtl/usb_rr_arbiter.sv
// ---------------------------------------------------------------------------
// usb_rr_arbiter
// Combinational round-robin selector. Searches req starting at ptr and
// returns the first requester found as a one-hot grant plus its index.
// Ports:
//   req  in  N_EP  request vector
//   ptr  in  IW    search start position (highest priority)
//   gnt  out N_EP  one-hot grant ('0 when no request)
//   idx  out IW    index of the granted requester
// ---------------------------------------------------------------------------
module usb_rr_arbiter #(
  parameter int unsigned N_EP = 4,
  localparam int unsigned IW  = (N_EP > 1) ? $clog2(N_EP) : 1
) (
  input  logic [N_EP-1:0] req,
  input  logic [IW-1:0]   ptr,
  output logic [N_EP-1:0] gnt,
  output logic [IW-1:0]   idx
);

  always_comb begin
    int unsigned cand;
    logic        found;
    gnt   = '0;
    idx   = '0;
    found = 1'b0;
    cand  = 0;
    for (int unsigned k = 0; k < N_EP; k++) begin
      cand = (32'(ptr) + k) % N_EP;
      if (!found && req[IW'(cand)]) begin
        found            = 1'b1;
        gnt[IW'(cand)]   = 1'b1;
        idx              = IW'(cand);
      end
    end
  end

endmodule

// File: rtl/usb_host_sched.sv
// ---------------------------------------------------------------------------
// usb_host_sched
// Host-side USB transaction scheduler (master mode only). Arbitrates
// round-robin among N_EP requesters and runs one IN or OUT transaction at a
// time: token -> data -> handshake, with retry and error reporting.
//
// Configuration macro: USB_SCHED_RETRY_EN
//   defined   : NAK / timeout / CRC16 error retries up to MAX_RETRY times
//   undefined : those events end the transaction in error immediately
//
// Ports:
//   clk, rst_n          clock, asynchronous active-low reset
//   ms                  1 = master mode; 0 holds the block idle
//   ep_req/dir/addr/endp per-requester request, direction (1=IN), address,
//                       endpoint (slice i belongs to requester i)
//   ep_gnt              one-hot grant held for the whole transaction
//   ep_done / ep_err    1-cycle success / failure pulse
//   tok_start/pid/addr/endp  token transmitter control
//   hs_start / hs_pid   handshake transmitter control (always ACK)
//   tx_lp_eop_en        end of any transmitted packet
//   rx_pid_en/rx_pid/crc5_err    received PID event and its qualifier
//   rx_lt_eop_en/rx_crc16_err    end of received DATA packet and its CRC
//   time_out            response timeout
//   busy                high whenever the scheduler is not IDLE
// ---------------------------------------------------------------------------
module usb_host_sched
  import usb_pkg::*;
#(
  parameter int unsigned N_EP      = 4,
  parameter int unsigned MAX_RETRY = 3,
  parameter int unsigned GAP_CYC   = 8
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              ms,
  input  logic [N_EP-1:0]   ep_req,
  input  logic [N_EP-1:0]   ep_dir,
  input  logic [7*N_EP-1:0] ep_addr,
  input  logic [4*N_EP-1:0] ep_endp,
  output logic [N_EP-1:0]   ep_gnt,
  output logic [N_EP-1:0]   ep_done,
  output logic [N_EP-1:0]   ep_err,
  output logic              tok_start,
  output logic [3:0]        tok_pid,
  output logic [6:0]        tok_addr,
  output logic [3:0]        tok_endp,
  output logic              hs_start,
  output logic [3:0]        hs_pid,
  input  logic              tx_lp_eop_en,
  input  logic              rx_pid_en,
  input  logic [3:0]        rx_pid,
  input  logic              crc5_err,
  input  logic              rx_lt_eop_en,
  input  logic              rx_crc16_err,
  input  logic              time_out,
  output logic              busy
);

  localparam int unsigned IW = (N_EP > 1) ? $clog2(N_EP) : 1;
  localparam int unsigned RW = (MAX_RETRY > 0) ? $clog2(MAX_RETRY + 1) : 1;
  localparam logic [RW-1:0] RETRY_MAX = RW'(MAX_RETRY);
  localparam logic [7:0]    GAP_LOAD  = 8'(GAP_CYC);

`ifdef USB_SCHED_RETRY_EN
  localparam bit RETRY_EN = 1'b1;
`else
  localparam bit RETRY_EN = 1'b0;
`endif

  sched_state_e    state, state_nxt, fail_st;
  logic [IW-1:0]   idx, rr_ptr, arb_idx;
  logic [N_EP-1:0] arb_gnt;
  logic            dir, sel_dir;
  logic [6:0]      sel_addr;
  logic [3:0]      sel_endp;
  logic [RW-1:0]   retry_cnt;
  logic [7:0]      gap_cnt;
  logic            hs_sent;
  logic            take, retry_inc, gap_load, pid_ev;

  usb_rr_arbiter #(.N_EP(N_EP)) u_arb (
    .req (ep_req),
    .ptr (rr_ptr),
    .gnt (arb_gnt),
    .idx (arb_idx)
  );

  // Per-requester fields of the arbitration winner
  always_comb begin
    sel_addr = '0;
    sel_endp = '0;
    for (int unsigned i = 0; i < N_EP; i++) begin
      if (arb_gnt[i]) begin
        sel_addr = ep_addr[7*i +: 7];
        sel_endp = ep_endp[4*i +: 4];
      end
    end
  end
  assign sel_dir = |(ep_dir & arb_gnt);

  assign pid_ev = rx_pid_en && !crc5_err;
  assign busy   = (state != ST_IDLE);
  assign hs_pid = PID_ACK;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    take      = 1'b0;
    retry_inc = 1'b0;
    // Retry budget is checked where the failure is seen, so RETRY is only
    // ever entered when another attempt is allowed; exhausting it goes
    // straight to ERR.
    fail_st   = (RETRY_EN && (retry_cnt < RETRY_MAX)) ? ST_RETRY : ST_ERR;

    case (state)
      ST_IDLE: begin
        if (ms && (|ep_req) && (gap_cnt == '0)) begin
          take      = 1'b1;
          state_nxt = ST_TOKEN;
        end
      end
      ST_TOKEN:    state_nxt = ST_TOK_WAIT;
      ST_TOK_WAIT: begin
        if (tx_lp_eop_en) state_nxt = dir ? ST_WAIT_DATA : ST_DATA_TX;
      end
      ST_DATA_TX: begin
        if (tx_lp_eop_en) state_nxt = ST_WAIT_HS;
      end
      ST_WAIT_HS: begin
        // A valid PID event takes precedence over a coincident timeout
        if (pid_ev) begin
          case (rx_pid)
            PID_ACK:   state_nxt = ST_DONE;
            PID_NAK:   state_nxt = fail_st;
            PID_STALL: state_nxt = ST_ERR;
            default:   state_nxt = state;
          endcase
        end else if (time_out) begin
          state_nxt = fail_st;
        end
      end
      ST_WAIT_DATA: begin
        if (pid_ev && (rx_pid == PID_NAK)) begin
          state_nxt = fail_st;
        end else if (pid_ev && (rx_pid == PID_STALL)) begin
          state_nxt = ST_ERR;
        end else if (rx_lt_eop_en) begin
          state_nxt = rx_crc16_err ? fail_st : ST_SEND_ACK;
        end else if (time_out && !pid_ev) begin
          state_nxt = fail_st;
        end
      end
      ST_SEND_ACK: begin
        if (tx_lp_eop_en && hs_sent) state_nxt = ST_DONE;
      end
`ifdef USB_SCHED_RETRY_EN
      ST_RETRY: begin
        if (gap_cnt == '0) begin
          retry_inc = 1'b1;
          state_nxt = ST_TOKEN;
        end
      end
`endif
      ST_DONE:  state_nxt = ST_IDLE;
      ST_ERR:   state_nxt = ST_IDLE;
      default:  state_nxt = ST_IDLE;
    endcase

    // Leaving master mode aborts any open transaction
    if (!ms && !(state inside {ST_IDLE, ST_DONE, ST_ERR})) state_nxt = ST_ERR;

    gap_load = (state == ST_DONE) || (state == ST_ERR) ||
               ((state_nxt == ST_RETRY) && (state != ST_RETRY));
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx       <= '0;
      rr_ptr    <= '0;
      dir       <= 1'b0;
      retry_cnt <= '0;
      gap_cnt   <= '0;
      hs_sent   <= 1'b0;
      ep_gnt    <= '0;
      ep_done   <= '0;
      ep_err    <= '0;
      tok_start <= 1'b0;
      tok_pid   <= '0;
      tok_addr  <= '0;
      tok_endp  <= '0;
      hs_start  <= 1'b0;
    end else begin
      tok_start <= (state == ST_TOKEN);
      hs_start  <= (state == ST_SEND_ACK) && !hs_sent;
      hs_sent   <= (state == ST_SEND_ACK);
      ep_done   <= '0;
      ep_err    <= '0;

      if (take) begin
        idx       <= arb_idx;
        dir       <= sel_dir;
        ep_gnt    <= arb_gnt;
        retry_cnt <= '0;
        tok_pid   <= sel_dir ? PID_IN : PID_OUT;
        tok_addr  <= sel_addr;
        tok_endp  <= sel_endp;
      end

      if (retry_inc) retry_cnt <= retry_cnt + 1'b1;

      if ((state == ST_DONE) || (state == ST_ERR)) begin
        ep_done <= (state == ST_DONE) ? ep_gnt : '0;
        ep_err  <= (state == ST_ERR)  ? ep_gnt : '0;
        ep_gnt  <= '0;
        rr_ptr  <= (idx == IW'(N_EP - 1)) ? '0 : idx + 1'b1;
      end

      if (gap_load) begin
        gap_cnt <= GAP_LOAD;
      end else if (((state == ST_IDLE) || (state == ST_RETRY)) && (gap_cnt != '0)) begin
        gap_cnt <= gap_cnt - 1'b1;
      end
    end
  end

endmodule

// File: tb/tb_usb_host_sched.sv
// ---------------------------------------------------------------------------
// tb_usb_host_sched
// Self-checking bench for usb_host_sched. Expected tokens and completion
// pulses are queued when a transaction is started and compared when the
// DUT emits tok_start / ep_done / ep_err. Honours USB_SCHED_RETRY_EN.
// ---------------------------------------------------------------------------
module tb_usb_host_sched;

  localparam int unsigned N   = 4;
  localparam int unsigned MAXR = 3;
  localparam int unsigned GAP = 8;
`ifdef USB_SCHED_RETRY_EN
  localparam int ATT = MAXR + 1;
`else
  localparam int ATT = 1;
`endif

  typedef struct packed {
    logic [3:0] pid;
    logic [6:0] addr;
    logic [3:0] endp;
  } tok_t;

  typedef struct packed {
    logic [3:0] done;
    logic [3:0] err;
  } res_t;

  logic           clk, rst_n, ms;
  logic [N-1:0]   ep_req, ep_dir, ep_gnt, ep_done, ep_err;
  logic [7*N-1:0] ep_addr;
  logic [4*N-1:0] ep_endp;
  logic           tok_start, hs_start, busy;
  logic [3:0]     tok_pid, tok_endp, hs_pid, rx_pid;
  logic [6:0]     tok_addr;
  logic           tx_lp_eop_en, rx_pid_en, crc5_err, rx_lt_eop_en, rx_crc16_err, time_out;

  usb_host_sched #(.N_EP(N), .MAX_RETRY(MAXR), .GAP_CYC(GAP)) dut (
    .clk(clk), .rst_n(rst_n), .ms(ms),
    .ep_req(ep_req), .ep_dir(ep_dir), .ep_addr(ep_addr), .ep_endp(ep_endp),
    .ep_gnt(ep_gnt), .ep_done(ep_done), .ep_err(ep_err),
    .tok_start(tok_start), .tok_pid(tok_pid), .tok_addr(tok_addr), .tok_endp(tok_endp),
    .hs_start(hs_start), .hs_pid(hs_pid),
    .tx_lp_eop_en(tx_lp_eop_en), .rx_pid_en(rx_pid_en), .rx_pid(rx_pid),
    .crc5_err(crc5_err), .rx_lt_eop_en(rx_lt_eop_en), .rx_crc16_err(rx_crc16_err),
    .time_out(time_out), .busy(busy)
  );

  logic [6:0] addr_tab [4] = '{7'h11, 7'h05, 7'h22, 7'h33};
  logic [3:0] endp_tab [4] = '{4'd1, 4'd2, 4'd3, 4'd4};

  tok_t tok_q [$];
  res_t res_q [$];
  int   n_chk = 0, n_fail = 0;
  int   tok_cnt = 0, hs_cnt = 0, cyc = 0, last_tok_cyc = 0;

  initial clk = 1'b0;
  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
    end
  endtask

  function automatic tok_t exp_tok(input int r, input logic in_dir);
    tok_t t;
    t.pid  = in_dir ? 4'b1001 : 4'b0001;
    t.addr = addr_tab[r];
    t.endp = endp_tab[r];
    return t;
  endfunction

  function automatic res_t mk_res(input logic [3:0] d, input logic [3:0] e);
    res_t r;
    r.done = d;
    r.err  = e;
    return r;
  endfunction

  // Monitor / scoreboard consumer
  initial forever begin
    @(negedge clk);
    if (rst_n) begin
      if (tok_start) begin
        tok_cnt++;
        last_tok_cyc = cyc;
        if (tok_q.size() == 0) check_val("tok_unexpected", 32'(tok_start), 32'(0));
        else begin
          tok_t e;
          e = tok_q.pop_front();
          check_val("tok_pid", 32'(tok_pid), 32'(e.pid));
          check_val("tok_addr", 32'(tok_addr), 32'(e.addr));
          check_val("tok_endp", 32'(tok_endp), 32'(e.endp));
        end
      end
      if (hs_start) begin
        hs_cnt++;
        check_val("hs_pid", 32'(hs_pid), 32'(4'b0010));
      end
      if ((|ep_done) || (|ep_err)) begin
        if (res_q.size() == 0) check_val("res_unexpected", 32'({ep_done, ep_err}), 32'(0));
        else begin
          res_t e;
          e = res_q.pop_front();
          check_val("res_done", 32'(ep_done), 32'(e.done));
          check_val("res_err", 32'(ep_err), 32'(e.err));
          check_val("gnt_drop", 32'(ep_gnt), 32'(0));
        end
      end
    end
  end

  task automatic step(input int n = 1);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic pulse_tx_eop();
    tx_lp_eop_en = 1'b1;
    step();
    tx_lp_eop_en = 1'b0;
  endtask

  task automatic send_pid(input logic [3:0] p, input logic bad, input logic to);
    rx_pid = p; rx_pid_en = 1'b1; crc5_err = bad; time_out = to;
    step();
    rx_pid_en = 1'b0; crc5_err = 1'b0; time_out = 1'b0;
  endtask

  task automatic wait_tok(input int n);
    int k = 0;
    while (tok_cnt < n && k < 200) begin step(); k++; end
    if (tok_cnt < n) check_val("tok_wait_timeout", 32'(tok_cnt), 32'(n));
  endtask

  task automatic wait_res();
    int k = 0;
    while (res_q.size() > 0 && k < 300) begin step(); k++; end
    if (res_q.size() > 0) check_val("res_wait_timeout", 32'(res_q.size()), 32'(0));
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    step(2);
    rst_n = 1'b1;
    step();
  endtask

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1);
  end

  initial begin
    int base, to_cyc;
    rst_n = 1'b0; ms = 1'b1; ep_req = '0; ep_dir = '0;
    ep_addr = {addr_tab[3], addr_tab[2], addr_tab[1], addr_tab[0]};
    ep_endp = {endp_tab[3], endp_tab[2], endp_tab[1], endp_tab[0]};
    tx_lp_eop_en = 0; rx_pid_en = 0; rx_pid = '0; crc5_err = 0;
    rx_lt_eop_en = 0; rx_crc16_err = 0; time_out = 0;
    step(3);

    // Reset values
    check_val("rst_gnt", 32'(ep_gnt), 32'(0));
    check_val("rst_tok_start", 32'(tok_start), 32'(0));
    check_val("rst_tok_pid", 32'(tok_pid), 32'(0));
    check_val("rst_busy", 32'(busy), 32'(0));
    check_val("rst_hs_pid", 32'(hs_pid), 32'(4'b0010));
    check_val("rst_done_err", 32'({ep_done, ep_err, hs_start}), 32'(0));
    rst_n = 1'b1;
    step();

    // Requester 1 OUT, ACKed; request dropped right after grant
    tok_q.push_back(exp_tok(1, 1'b0));
    res_q.push_back(mk_res(4'b0010, 4'b0000));
    ep_req = 4'b0010;
    step();
    check_val("arb_latency_gnt", 32'(ep_gnt), 32'(4'b0010));
    check_val("tok_not_yet", 32'(tok_start), 32'(0));
    check_val("busy_on", 32'(busy), 32'(1));
    ep_req = '0;
    step();
    check_val("tok_latency", 32'(tok_start), 32'(1));
    pulse_tx_eop();
    pulse_tx_eop();
    check_val("tok_hold_pid", 32'(tok_pid), 32'(4'b0001));
    check_val("tok_hold_addr", 32'(tok_addr), 32'(7'h05));
    check_val("tok_hold_endp", 32'(tok_endp), 32'(2));
    send_pid(4'b0010, 1'b0, 1'b0);
    wait_res();
    check_val("busy_off_out", 32'(busy), 32'(0));

    // Requester 0 IN, data OK -> ACK handshake -> done
    tok_q.push_back(exp_tok(0, 1'b1));
    res_q.push_back(mk_res(4'b0001, 4'b0000));
    ep_dir = 4'b0001; ep_req = 4'b0001;
    wait_tok(tok_cnt + 1);
    ep_req = '0;
    pulse_tx_eop();
    send_pid(4'b0011, 1'b0, 1'b0);   // DATA0 PID, no effect
    rx_lt_eop_en = 1'b1; rx_crc16_err = 1'b0;
    step();
    rx_lt_eop_en = 1'b0;
    begin
      int k = 0;
      while (hs_cnt < 1 && k < 20) begin step(); k++; end
    end
    check_val("in_hs_count", 32'(hs_cnt), 32'(1));
    pulse_tx_eop();
    wait_res();

    // OUT with timeout on every attempt
    base = tok_cnt;
    for (int a = 0; a < ATT; a++) tok_q.push_back(exp_tok(2, 1'b0));
    res_q.push_back(mk_res(4'b0000, 4'b0100));
    ep_dir = '0; ep_req = 4'b0100;
    to_cyc = 0;
    for (int a = 0; a < ATT; a++) begin
      wait_tok(base + a + 1);
      if (a == 0) ep_req = '0;
      else check_val("retry_gap_ok", 32'((last_tok_cyc - to_cyc) >= int'(GAP)), 32'(1));
      pulse_tx_eop();
      pulse_tx_eop();
      time_out = 1'b1;
      to_cyc = cyc;
      step();
      time_out = 1'b0;
    end
    wait_res();
    step(30);
    check_val("retry_tok_count", 32'(tok_cnt - base), 32'(ATT));

    // Round robin with all four requesting, from a fresh pointer
    do_reset();
    for (int i = 0; i < 5; i++) begin
      tok_q.push_back(exp_tok(i % 4, 1'b0));
      res_q.push_back(mk_res(4'(1 << (i % 4)), 4'b0000));
    end
    base = tok_cnt;
    ep_dir = '0; ep_req = 4'b1111;
    for (int i = 0; i < 5; i++) begin
      wait_tok(base + i + 1);
      check_val("rr_gnt", 32'(ep_gnt), 32'(1 << (i % 4)));
      pulse_tx_eop();
      pulse_tx_eop();
      send_pid(4'b0010, 1'b0, 1'b0);
      if (i == 4) ep_req = '0;
    end
    wait_res();

    // STALL -> error without retry; then re-grant, crc5-bad ACK ignored,
    // ACK coincident with timeout -> done
    base = tok_cnt;
    tok_q.push_back(exp_tok(3, 1'b0));
    tok_q.push_back(exp_tok(3, 1'b0));
    res_q.push_back(mk_res(4'b0000, 4'b1000));
    res_q.push_back(mk_res(4'b1000, 4'b0000));
    ep_req = 4'b1000;
    wait_tok(base + 1);
    pulse_tx_eop();
    pulse_tx_eop();
    send_pid(4'b1110, 1'b0, 1'b0);
    step(3);
    check_val("stall_err_seen", 32'(res_q.size()), 32'(1));
    wait_tok(base + 2);
    ep_req = '0;
    pulse_tx_eop();
    pulse_tx_eop();
    send_pid(4'b0010, 1'b1, 1'b0);
    step(3);
    check_val("crc5_ignored", 32'(busy), 32'(1));
    send_pid(4'b0010, 1'b0, 1'b1);
    wait_res();
    step(20);
    check_val("stall_tok_count", 32'(tok_cnt - base), 32'(2));

    // ms dropped in WAIT_DATA
    tok_q.push_back(exp_tok(0, 1'b1));
    res_q.push_back(mk_res(4'b0000, 4'b0001));
    ep_dir = 4'b0001; ep_req = 4'b0001;
    wait_tok(tok_cnt + 1);
    ep_req = '0;
    pulse_tx_eop();
    ms = 1'b0;
    step();
    check_val("ms_err_not_yet", 32'(ep_err), 32'(0));
    step();
    check_val("ms_drop_err", 32'(ep_err), 32'(4'b0001));
    check_val("ms_idle", 32'(busy), 32'(0));
    ms = 1'b1;
    step(2);
    wait_res();

    // Asynchronous reset during DATA_TX
    tok_q.push_back(exp_tok(1, 1'b0));
    ep_dir = '0; ep_req = 4'b0010;
    wait_tok(tok_cnt + 1);
    pulse_tx_eop();
    #2;
    rst_n = 1'b0;
    #1;
    check_val("arst_gnt", 32'(ep_gnt), 32'(0));
    check_val("arst_busy", 32'(busy), 32'(0));
    check_val("arst_tok", 32'({tok_start, tok_pid, tok_addr, tok_endp}), 32'(0));
    check_val("arst_pulses", 32'({hs_start, ep_done, ep_err}), 32'(0));
    ep_req = '0;
    #3;
    rst_n = 1'b1;
    step(3);

    check_val("hs_total", 32'(hs_cnt), 32'(1));
    check_val("tok_q_empty", 32'(tok_q.size()), 32'(0));
    check_val("res_q_empty", 32'(res_q.size()), 32'(0));

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule

// File: doc/usb_host_sched.md
# usb_host_sched

Host-side transaction scheduler for the USB link layer. It arbitrates round-robin among up to N_EP endpoint requesters and sequences one IN or OUT transaction at a time: token, then data, then handshake. It drives the token and handshake transmitters and consumes the same pulse events `link_control` uses, with retry and error reporting. It is active only in master mode (ms=1).

## Interface
Parameters:
- N_EP, 4: number of requesters (2..8).
- MAX_RETRY, 3: retries after NAK, timeout or bad data before error.
- GAP_CYC, 8: idle cycles enforced between transactions (8-bit counter).

Ports:
- clk  in  1  clock.
- rst_n  in  1  reset, asynchronous, active-low.
- ms  in  1  1 = master; 0 = block held idle.
- ep_req  in  N_EP  level request per requester.
- ep_dir  in  N_EP  1 = IN (read), 0 = OUT (write).
- ep_addr  in  7*N_EP  device address; slice i belongs to requester i.
- ep_endp  in  4*N_EP  endpoint number; slice i belongs to requester i.
- ep_gnt  out  N_EP  one-hot grant, held for the whole transaction.
- ep_done  out  N_EP  1-cycle success pulse.
- ep_err  out  N_EP  1-cycle failure pulse.
- tok_start  out  1  1-cycle pulse starting a token packet.
- tok_pid  out  4  token PID.
- tok_addr  out  7  token address.
- tok_endp  out  4  token endpoint.
- hs_start  out  1  1-cycle pulse starting a handshake packet.
- hs_pid  out  4  handshake PID; always ACK (0010).
- tx_lp_eop_en  in  1  pulse at end of any transmitted packet.
- rx_pid_en  in  1  pulse when a received PID is valid.
- rx_pid  in  4  received PID.
- crc5_err  in  1  qualifies rx_pid_en.
- rx_lt_eop_en  in  1  pulse at end of a received DATA packet.
- rx_crc16_err  in  1  valid together with rx_lt_eop_en.
- time_out  in  1  timeout flag from `link_control`.
- busy  out  1  high whenever state is not IDLE.

## Operation
State machine:
- IDLE
  - Wait for ms=1, |ep_req, and gap counter = 0.
  - Select the next requester round-robin, searching from rr_ptr.
  - Latch its index, dir, addr and endp; assert ep_gnt; clear retry_cnt.
  - Go to TOKEN.
- TOKEN
  - Pulse tok_start. PID = 1001 (IN) or 0001 (OUT).
  - Go to TOK_WAIT.
- TOK_WAIT
  - On tx_lp_eop_en: OUT goes to DATA_TX; IN goes to WAIT_DATA.
- DATA_TX
  - On tx_lp_eop_en (DATA packet sent via tx_data_on path): go to WAIT_HS.
- WAIT_HS
  - rx_pid_en with !crc5_err:
    - ACK (0010): go to DONE.
    - NAK (1010): go to RETRY.
    - STALL (1110): go to ERR, no retry.
    - Any other PID: ignored.
  - time_out: go to RETRY.
- WAIT_DATA
  - rx_lt_eop_en with !rx_crc16_err: go to SEND_ACK.
  - rx_lt_eop_en with rx_crc16_err: go to RETRY, and no handshake is sent.
  - time_out: go to RETRY.
  - rx_pid_en with NAK: go to RETRY. With STALL: go to ERR.
- SEND_ACK
  - Pulse hs_start once; go to DONE on tx_lp_eop_en.
- RETRY
  - If retry_cnt < MAX_RETRY: increment it, load the gap counter, and return to TOKEN once the gap expires.
  - Otherwise go to ERR.
- DONE / ERR
  - Pulse ep_done[idx] / ep_err[idx]; drop ep_gnt.
  - Set rr_ptr = idx+1 mod N_EP; load the gap counter; go to IDLE.

Boundary rules:
- rx_pid_en and time_out in the same cycle: the PID wins.
- ms falls mid-transaction: go to ERR next cycle and pulse ep_err for the granted requester.
- ep_req dropped after grant: ignored; the transaction completes.
- Only one requester: it is re-granted after the gap.
- rx_pid_en with crc5_err: ignored entirely.

## Timing
- Reset values:
  - All outputs 0; hs_pid = 0010.
  - State IDLE; rr_ptr = 0; retry_cnt = 0; gap counter = 0.
- Arbitration latency: request seen in IDLE produces ep_gnt on the next edge, and tok_start one cycle later.
- tok_pid, tok_addr and tok_endp stay stable from tok_start until ep_gnt drops.
- ep_done / ep_err are asserted in the same cycle that ep_gnt drops, exactly one cycle wide.
- Gap counter:
  - Loads GAP_CYC, counts down in IDLE and RETRY, saturates at 0.
  - With GAP_CYC = 0 there is no extra delay.
- retry_cnt width is clog2(MAX_RETRY+1).

## Configuration
- USB_SCHED_RETRY_EN defined: behaviour is as above.
- USB_SCHED_RETRY_EN undefined: the RETRY state is not built; every NAK, timeout or CRC16 error goes directly to ERR, and MAX_RETRY is ignored.

## Structure
- Shared package `usb_pkg`:
  - PID constants PID_OUT, PID_IN, PID_ACK, PID_NAK, PID_STALL.
  - Scheduler state enum.
- Sub-module `usb_rr_arbiter`:
  - Parameter N_EP.
  - Inputs req and ptr; outputs one-hot grant and index.
  - Purely combinational, instantiated once.

## Test plan
- Requester 1 OUT (addr 0x05, endp 2): tok_pid=0001, addr 0x05, endp 2 → after two tx_lp_eop_en, inject ACK → ep_done[1] pulse, busy falls.
- Requester 0 IN: after token, rx_lt_eop_en with crc ok → hs_start pulse with hs_pid=0010 → after tx_lp_eop_en, ep_done[0].
- OUT with time_out on every attempt, MAX_RETRY=3 → 4 tok_start pulses, each separated by ≥8 idle cycles → ep_err pulse. Repeat with macro off → 1 token, then err.
- ep_req=4'b1111 held: grant order 0,1,2,3,0, with each transaction ACKed.
- STALL in WAIT_HS → ep_err with no retry. rx_pid_en=ACK together with time_out → ep_done.
- ms dropped in WAIT_DATA → ep_err next cycle, then IDLE. Async reset mid-DATA_TX → all outputs 0 immediately.
